// File: rtl/mag_sum_arbiter.sv
// mag_sum_arbiter: round-robin share of one 2-stage |a|+|b| pipeline among N_CH requesters
module mag_sum_arbiter #(
  parameter int W_IN  = 26,
  parameter int W_OUT = 27,
  parameter int N_CH  = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        req_valid,
  input  logic [N_CH*W_IN-1:0]   req_a,
  input  logic [N_CH*W_IN-1:0]   req_b,
  output logic [N_CH-1:0]        req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH_W-1:0]        out_ch,
  output logic [W_OUT-1:0]       out_mag,
  output logic                   busy
);
  logic [CH_W-1:0] rr_ptr, g, s1_ch;
  logic [W_IN-1:0] s1_a, s1_b, sel_a, sel_b, abs_a, abs_b;
  logic            s1_valid, found, adv1, adv2;
  always_comb begin
    found = 1'b0;
    g = '0;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (req_valid[(int'(rr_ptr) + i) % N_CH]) begin
        found = 1'b1;
        g = CH_W'((int'(rr_ptr) + i) % N_CH);
      end
    end
  end
  assign adv2      = !out_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign req_ready = (found && adv1 && rst_n) ? N_CH'(1) << g : '0;
  assign sel_a     = req_a[g*W_IN +: W_IN];
  assign sel_b     = req_b[g*W_IN +: W_IN];
  // the most-negative input negates to 100..0, which read unsigned is its true magnitude
  assign abs_a     = sel_a[W_IN-1] ? -sel_a : sel_a;
  assign abs_b     = sel_b[W_IN-1] ? -sel_b : sel_b;
  assign busy      = s1_valid | out_valid;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_ch     <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_mag   <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= found;
        if (found) begin
          s1_a   <= abs_a;
          s1_b   <= abs_b;
          s1_ch  <= g;
          rr_ptr <= (g == CH_W'(N_CH-1)) ? '0 : g + 1'b1;
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_mag <= W_OUT'(s1_a) + W_OUT'(s1_b);
          out_ch  <= s1_ch;
        end
      end
    end
  end
endmodule

// File: tb/tb_mag_sum_arbiter.sv
// tb_mag_sum_arbiter: directed checks of arbitration, latency, extremes, backpressure and reset
module tb_mag_sum_arbiter;
  localparam int W = 26;
  localparam int WO = 27;
  localparam int N = 4;
  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           out_valid, out_ready, busy;
  logic [1:0]     out_ch;
  logic [WO-1:0]  out_mag;
  int errors = 0;
  int checks = 0;
  int mags[4] = '{1, 102, 203, 304};
  mag_sum_arbiter #(.W_IN(W), .W_OUT(WO), .N_CH(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_mag(out_mag), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_ch(input int k, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    req_a[k*W +: W] = a;
    req_b[k*W +: W] = b;
  endtask
  initial begin
    rst_n = 1'b0;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rst_ready", req_ready, 0);
      check("rst_valid", out_valid, 0);
      check("rst_mag", out_mag, 0);
      check("rst_busy", busy, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b0100;
    set_ch(2, -26'sd5, 26'sd7);
    #1 check("single_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("single_noregrant", req_ready, 0);
    check("single_lat_valid", out_valid, 0);
    check("single_busy", busy, 1);
    @(negedge clk); #1;
    check("single_valid", out_valid, 1);
    check("single_ch", out_ch, 2);
    check("single_mag", out_mag, 12);
    @(negedge clk);
    set_ch(0, -26'sd33554432, -26'sd33554432);
    req_valid = 4'b0001;
    #1 check("ext_grant1", req_ready, 4'b0001);
    @(negedge clk);
    set_ch(0, 26'sd33554431, 26'sd0);
    #1 check("ext_grant2", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("ext_min_mag", out_mag, 27'h400_0000);
    check("ext_min_ch", out_ch, 0);
    @(negedge clk);
    req_valid = 4'b1000;
    set_ch(3, 26'sd1, 26'sd1);
    #1;
    check("ext_max_mag", out_mag, 27'h1FF_FFFF);
    check("align_grant3", req_ready, 4'b1000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0)
        for (int k = 0; k < 4; k++) set_ch(k, -(k + 1), 100 * k);
      req_valid = (i < 8) ? 4'b1111 : 4'b0000;
      #1;
      check("rr_grant", req_ready, (i < 8) ? (1 << (i % 4)) : 0);
      if (i == 0) check("rr_bubble", out_valid, 0);
      if (i == 1) begin
        check("rr_ch3_pre", out_ch, 3);
        check("rr_mag3_pre", out_mag, 2);
      end
      if (i >= 2) begin
        check("rr_valid", out_valid, 1);
        check("rr_ch", out_ch, (i - 2) % 4);
        check("rr_mag", out_mag, mags[(i - 2) % 4]);
      end
    end
    @(negedge clk); #1;
    check("rr_drained", out_valid, 0);
    check("rr_idle", busy, 0);
    @(negedge clk);
    set_ch(0, 26'sd3, 26'sd4);
    set_ch(1, -26'sd10, -26'sd20);
    req_valid = 4'b0011;
    out_ready = 1'b0;
    #1 check("bp_grant0", req_ready, 4'b0001);
    @(negedge clk); #1;
    check("bp_grant1", req_ready, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("bp_stall", req_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ch", out_ch, 0);
      check("bp_hold_mag", out_mag, 7);
    end
    @(negedge clk);
    out_ready = 1'b1;
    req_valid = '0;
    #1;
    check("bp_rel_ch", out_ch, 0);
    check("bp_rel_mag", out_mag, 7);
    @(negedge clk); #1;
    check("bp_drain_valid", out_valid, 1);
    check("bp_drain_ch", out_ch, 1);
    check("bp_drain_mag", out_mag, 30);
    @(negedge clk); #1;
    check("bp_empty", out_valid, 0);
    check("bp_idle", busy, 0);
    @(negedge clk);
    set_ch(2, 26'sd8, -26'sd8);
    req_valid = 4'b0100;
    out_ready = 1'b0;
    #1 check("mr_fill1", req_ready, 4'b0100);
    @(negedge clk); #1;
    check("mr_fill2", req_ready, 4'b0100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_full_valid", out_valid, 1);
    check("mr_full_ch", out_ch, 2);
    check("mr_full_busy", busy, 1);
    check("mr_rst_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_ch(1, 26'sd2, 26'sd3);
    set_ch(3, 26'sd9, 26'sd9);
    req_valid = 4'b1010;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_mag", out_mag, 0);
    check("mr_first_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    check("mr_out_ch", out_ch, 1);
    check("mr_out_mag", out_mag, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mag_sum_arbiter.md
# mag_sum_arbiter

Round-robin scheduler that shares one registered |a|+|b| magnitude datapath among N_CH requesters (I/Q channel pairs feeding the EMA/AGC level detectors). Each requester presents a signed sample pair with a valid/ready handshake. The block grants at most one requester per cycle and pushes the pair through a 2-stage pipeline (absolute value, then sum). It returns the unsigned magnitude tagged with the channel index on a single backpressured output port.

## Interface
- W_IN, default 26: signed width of each input sample.
- W_OUT, default 27: unsigned width of the magnitude sum. Must be ≥ W_IN+1.
- N_CH, default 4: number of requesters. Range 2..16. CH_W = clog2(N_CH).

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- req_valid, input, N_CH: per-channel request valid.
- req_a, input, N_CH*W_IN: channel k's sample A is at bits [k*W_IN +: W_IN]. Two's complement.
- req_b, input, N_CH*W_IN: channel k's sample B, same packing.
- req_ready, output, N_CH: one-hot grant. Bit k high means channel k's pair is accepted this cycle.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_ch, output, CH_W: channel index of the result.
- out_mag, output, W_OUT: |A|+|B|, unsigned.
- busy, output, 1: any pipeline stage holds valid data.

## Operation
- Handshake: a channel transfers when req_valid[k] && req_ready[k].
  - Output transfers when out_valid && out_ready.
  - A requester must hold req_valid and its data stable until accepted.
- Arbitration:
  - Round-robin pointer rr_ptr (CH_W bits).
  - Search order is rr_ptr, rr_ptr+1, …, wrapping modulo N_CH. The first valid channel wins.
  - After a grant to channel g, rr_ptr ← (g+1) mod N_CH. No grant leaves rr_ptr unchanged.
- Grant is issued only when stage 1 can accept: adv1 = !s1_valid || adv2, where adv2 = !s2_valid || out_ready.
  - req_ready is combinational from req_valid, rr_ptr and adv1. It must not depend on req_a or req_b.
- Stage 1 (on grant):
  - abs_a, abs_b are W_IN-bit unsigned values: x if x[W_IN-1]==0, else the two's-complement negation of x.
  - The most-negative input −2^(W_IN−1) yields bit pattern 100…0. Read as unsigned this is 2^(W_IN−1), which is the correct magnitude, so there is no saturation.
  - The channel tag is stored with the values.
- Stage 2: out_mag ← zero-extend(abs_a) + zero-extend(abs_b) in W_OUT bits. The maximum value 2^W_IN never overflows.
- Stall:
  - When out_valid && !out_ready, stage 2 holds.
  - Stage 1 holds if it is full.
  - No grants are issued while stage 1 cannot advance.
  - No data is dropped or duplicated.
- Bubbles: when adv1 is high and no request is present, s1_valid ← 0. When stage 2 advances from an empty stage 1, s2_valid ← 0.
- busy = s1_valid | s2_valid.

## Timing
- Reset (rst_n low at a rising edge) values:
  - rr_ptr=0, s1_valid=0, s2_valid=0.
  - out_valid=0, out_ch=0, out_mag=0.
  - req_ready=0 for that cycle, busy=0.
- Reset mid-operation discards in-flight results. Requesters re-present their data after reset.
- Latency: a grant at edge T gives out_valid=1 with data after edge T+1. That is 2 cycles from req_valid sampled to out_valid, with no stalls.
- Throughput: 1 result per cycle with out_ready held high, under any request pattern.
- Fairness: with all N_CH channels continuously valid, each channel is granted exactly once per N_CH consecutive grants.
- Simultaneous events:
  - Output transfer and new grant in the same cycle is allowed (adv2 chains into adv1).
  - A channel dropping req_valid in the cycle its grant would occur is simply skipped. No grant is issued to a non-valid channel.
- Stalls: out_mag and out_ch stay stable while out_valid && !out_ready.

## Test plan
- Reset check: drive rst_n=0 for 3 cycles with all req_valid=1. Required: req_ready=0, out_valid=0, out_mag=0, busy=0 throughout.
- Single channel: ch2 presents A=−5, B=7, out_ready=1. Required: req_ready=4'b0100 for one cycle; 2 cycles later out_valid=1, out_ch=2, out_mag=12.
- Extremes with W_IN=26: A=−2^25, B=−2^25. Required: out_mag=2^26 = 27'h400_0000. Then A=2^25−1, B=0 gives out_mag=2^25−1.
- Round-robin with all 4 channels valid for 8 cycles, out_ready=1. Required:
  - Grant order 0,1,2,3,0,1,2,3.
  - out_ch follows the same order, one per cycle after a 2-cycle latency.
  - rr_ptr wraps 3→0.
- Backpressure:
  - Stream ch0/ch1 with out_ready=0 for 5 cycles. Required: exactly 2 grants occur (pipeline fills), then req_ready=0; out_mag/out_ch hold constant.
  - Release out_ready. Required: results drain in grant order with no loss or duplication.
- Mid-operation reset: assert rst_n=0 while both stages are full. Required: next cycle out_valid=0, busy=0, rr_ptr=0. The first grant after release goes to the lowest-index valid channel.
